// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared RAM port B: registered req/ack handshake,
// one RAM transaction at a time, read data returned with a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RAM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RAM_LATENCY - 1);

  state_t     state, state_n;
  logic [1:0] wait_cnt;
  logic       last_grant;
  logic       we_q;
  logic       win;
  logic       any_req;

  always_comb begin
    any_req = req0 | req1;
    win     = 1'b0;
    if (req0 && req1)
      win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1)
      win = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (wait_cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Outputs are registered off the next state so busy/ack line up with the FSM
  // without any input-to-output combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      wait_cnt    <= '0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      ram_wren <= 1'b0;
      busy     <= (state_n != IDLE);
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id    <= win;
            ram_address <= win ? addr1  : addr0;
            ram_data    <= win ? wdata1 : wdata0;
            ram_wren    <= win ? we1    : we0;
            we_q        <= win ? we1    : we0;
          end
        end
        ISSUE: wait_cnt <= WAIT_INIT;
        WAIT: begin
          if (wait_cnt == '0) begin
            if (!we_q) begin
              if (grant_id) rdata1 <= ram_q;
              else          rdata0 <= ram_q;
            end
            if (grant_id) ack1 <= 1'b1;
            else          ack0 <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: last_grant <= grant_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench: three arbiter instances (round-robin, fixed
// priority, three-cycle RAM) each with a behavioural RAM on port B.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;

  logic        ack0_a, ack1_a, ram_wren_a, busy_a, grant_id_a;
  logic [15:0] rdata0_a, rdata1_a, ram_address_a, ram_data_a, ram_q_a;
  logic        ack0_b, ack1_b, ram_wren_b, busy_b, grant_id_b;
  logic [15:0] rdata0_b, rdata1_b, ram_address_b, ram_data_b, ram_q_b;
  logic        ack0_c, ack1_c, ram_wren_c, busy_c, grant_id_c;
  logic [15:0] rdata0_c, rdata1_c, ram_address_c, ram_data_c, ram_q_c;

  logic [15:0] mem_a [256] = '{16: 16'hBEEF, default: 16'h0000};
  logic [15:0] mem_b [256] = '{default: 16'h0000};
  logic [15:0] mem_c [256] = '{5: 16'h5555, 6: 16'h6666, default: 16'h0000};
  logic [15:0] p1_c = '0, p2_c = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren_a) mem_a[ram_address_a[7:0]] <= ram_data_a;
    ram_q_a <= mem_a[ram_address_a[7:0]];
    if (ram_wren_b) mem_b[ram_address_b[7:0]] <= ram_data_b;
    ram_q_b <= mem_b[ram_address_b[7:0]];
    if (ram_wren_c) mem_c[ram_address_c[7:0]] <= ram_data_c;
    p1_c    <= mem_c[ram_address_c[7:0]];
    p2_c    <= p1_c;
    ram_q_c <= p2_c;
  end

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(1), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a), .rdata1(rdata1_a),
    .ram_address(ram_address_a), .ram_data(ram_data_a), .ram_wren(ram_wren_a), .ram_q(ram_q_a),
    .busy(busy_a), .grant_id(grant_id_a));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(1), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b), .rdata1(rdata1_b),
    .ram_address(ram_address_b), .ram_data(ram_data_b), .ram_wren(ram_wren_b), .ram_q(ram_q_b),
    .busy(busy_b), .grant_id(grant_id_b));

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(3), .FIXED_PRIO(0)) dut_c (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_c), .rdata0(rdata0_c),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_c), .rdata1(rdata1_c),
    .ram_address(ram_address_c), .ram_data(ram_data_c), .ram_wren(ram_wren_c), .ram_q(ram_q_c),
    .busy(busy_c), .grant_id(grant_id_c));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'h0010; addr1 = 16'h0020; wdata0 = 16'hAAAA; wdata1 = 16'h5555;
    tick;
    tick;
    n_checks++; if ({ack0_a, ack1_a, ram_wren_a, busy_a, grant_id_a} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {ack0_a, ack1_a, ram_wren_a, busy_a, grant_id_a}); end
    n_checks++; if ({rdata0_a, rdata1_a} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", {rdata0_a, rdata1_a}); end
    n_checks++; if ({ram_address_a, ram_data_a} !== 32'h0) begin n_fail++; $display("FAIL reset_ram got %h exp 0", {ram_address_a, ram_data_a}); end
    n_checks++; if ({busy_b, busy_c, ram_wren_c} !== 3'b0) begin n_fail++; $display("FAIL reset_bc got %b exp 000", {busy_b, busy_c, ram_wren_c}); end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_read;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    for (int c = 1; c <= 6; c++) begin
      tick;
      n_checks++; if (ram_wren_a !== 1'b0) begin n_fail++; $display("FAIL read_wren c=%0d got %b exp 0", c, ram_wren_a); end
      n_checks++; if (ack0_a !== (c == 3)) begin n_fail++; $display("FAIL read_ack0 c=%0d got %b exp %b", c, ack0_a, c == 3); end
      n_checks++; if (ack1_a !== 1'b0) begin n_fail++; $display("FAIL read_ack1 c=%0d got %b exp 0", c, ack1_a); end
      n_checks++; if (busy_a !== (c <= 3)) begin n_fail++; $display("FAIL read_busy c=%0d got %b exp %b", c, busy_a, c <= 3); end
      if (c == 1) begin
        n_checks++; if (ram_address_a !== 16'h0010) begin n_fail++; $display("FAIL read_addr got %h exp 0010", ram_address_a); end
      end
      if (c == 3 || c == 6) begin
        n_checks++; if (rdata0_a !== 16'hBEEF) begin n_fail++; $display("FAIL read_rdata0 c=%0d got %h exp beef", c, rdata0_a); end
      end
      if (c == 3) req0 = 1'b0;
    end
  endtask

  task automatic test_write;
    pulse_reset;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      tick;
      n_checks++; if (ram_wren_a !== (c == 1)) begin n_fail++; $display("FAIL write_wren c=%0d got %b exp %b", c, ram_wren_a, c == 1); end
      n_checks++; if (ack1_a !== (c == 3)) begin n_fail++; $display("FAIL write_ack1 c=%0d got %b exp %b", c, ack1_a, c == 3); end
      n_checks++; if (ack0_a !== 1'b0) begin n_fail++; $display("FAIL write_ack0 c=%0d got %b exp 0", c, ack0_a); end
      if (c == 1) begin
        n_checks++; if ({ram_address_a, ram_data_a} !== {16'h0020, 16'h1234}) begin n_fail++; $display("FAIL write_bus got %h/%h exp 0020/1234", ram_address_a, ram_data_a); end
        n_checks++; if (grant_id_a !== 1'b1) begin n_fail++; $display("FAIL write_grant got %b exp 1", grant_id_a); end
      end
      if (c == 3) begin
        n_checks++; if (rdata1_a !== 16'h0000) begin n_fail++; $display("FAIL write_rdata1 got %h exp 0000", rdata1_a); end
        req1 = 1'b0; we1 = 1'b0;
      end
    end
    req1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      n_checks++; if (ack1_a !== (c == 3)) begin n_fail++; $display("FAIL readback_ack1 c=%0d got %b exp %b", c, ack1_a, c == 3); end
      if (c == 3) begin
        n_checks++; if (rdata1_a !== 16'h1234) begin n_fail++; $display("FAIL readback_rdata1 got %h exp 1234", rdata1_a); end
        req1 = 1'b0;
      end
    end
  endtask

  task automatic test_round_robin;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    for (int c = 1; c <= 16; c++) begin
      tick;
      n_checks++; if (ack0_a !== (c == 3 || c == 11)) begin n_fail++; $display("FAIL rr_ack0 c=%0d got %b exp %b", c, ack0_a, c == 3 || c == 11); end
      n_checks++; if (ack1_a !== (c == 7 || c == 15)) begin n_fail++; $display("FAIL rr_ack1 c=%0d got %b exp %b", c, ack1_a, c == 7 || c == 15); end
      if (c % 4 == 1) begin
        n_checks++; if (grant_id_a !== 1'((c / 4) % 2)) begin n_fail++; $display("FAIL rr_grant c=%0d got %b exp %0d", c, grant_id_a, (c / 4) % 2); end
      end
      if (c == 7) begin
        n_checks++; if (rdata1_a !== 16'h1234) begin n_fail++; $display("FAIL rr_rdata1 got %h exp 1234", rdata1_a); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_fixed_prio;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
    for (int c = 1; c <= 16; c++) begin
      tick;
      n_checks++; if (ack0_b !== (c == 3 || c == 7 || c == 11)) begin n_fail++; $display("FAIL fp_ack0 c=%0d got %b exp %b", c, ack0_b, c == 3 || c == 7 || c == 11); end
      n_checks++; if (ack1_b !== (c == 15)) begin n_fail++; $display("FAIL fp_ack1 c=%0d got %b exp %b", c, ack1_b, c == 15); end
      if (c == 11) req0 = 1'b0;
      if (c == 15) req1 = 1'b0;
    end
  endtask

  task automatic test_latency3;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0006;
    for (int c = 1; c <= 8; c++) begin
      tick;
      n_checks++; if (ack0_c !== (c == 5)) begin n_fail++; $display("FAIL lat3_first_ack0 c=%0d got %b exp %b", c, ack0_c, c == 5); end
      if (c == 5) begin
        n_checks++; if (rdata0_c !== 16'h6666) begin n_fail++; $display("FAIL lat3_first_rdata0 got %h exp 6666", rdata0_c); end
        req0 = 1'b0;
      end
    end
    req0 = 1'b1; addr0 = 16'h0005;
    for (int c = 1; c <= 7; c++) begin
      tick;
      n_checks++; if (ack0_c !== (c == 5)) begin n_fail++; $display("FAIL lat3_ack0 c=%0d got %b exp %b", c, ack0_c, c == 5); end
      n_checks++; if (busy_c !== (c <= 5)) begin n_fail++; $display("FAIL lat3_busy c=%0d got %b exp %b", c, busy_c, c <= 5); end
      if (c == 4) begin
        n_checks++; if (rdata0_c !== 16'h6666) begin n_fail++; $display("FAIL lat3_hold got %h exp 6666", rdata0_c); end
      end
      if (c == 5) begin
        n_checks++; if (rdata0_c !== 16'h5555) begin n_fail++; $display("FAIL lat3_rdata0 got %h exp 5555", rdata0_c); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
    for (int c = 1; c <= 10; c++) begin
      tick;
      n_checks++; if (ack0_c !== (c == 9)) begin n_fail++; $display("FAIL rmid_ack0 c=%0d got %b exp %b", c, ack0_c, c == 9); end
      if (c == 3) begin
        n_checks++; if (busy_c !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b exp 1", busy_c); end
        reset = 1'b1;
      end
      if (c == 4) begin
        n_checks++; if ({busy_c, ram_wren_c, rdata0_c} !== 18'h0) begin n_fail++; $display("FAIL rmid_after got %b/%b/%h exp 0/0/0000", busy_c, ram_wren_c, rdata0_c); end
        reset = 1'b0;
      end
      if (c == 5) begin
        n_checks++; if ({busy_c, ram_address_c} !== {1'b1, 16'h0005}) begin n_fail++; $display("FAIL rmid_reissue got %b/%h exp 1/0005", busy_c, ram_address_c); end
      end
      if (c == 9) begin
        n_checks++; if (rdata0_c !== 16'h5555) begin n_fail++; $display("FAIL rmid_rdata0 got %h exp 5555", rdata0_c); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back;
    pulse_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    for (int c = 1; c <= 10; c++) begin
      tick;
      n_checks++; if (ack0_a !== (c == 3 || c == 7)) begin n_fail++; $display("FAIL b2b_late_ack0 c=%0d got %b exp %b", c, ack0_a, c == 3 || c == 7); end
      if (c == 5) req0 = 1'b0;
    end
    pulse_reset;
    req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      n_checks++; if (ack0_a !== (c == 3)) begin n_fail++; $display("FAIL b2b_ontime_ack0 c=%0d got %b exp %b", c, ack0_a, c == 3); end
      if (c == 4) req0 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset;
    test_read;
    test_write;
    test_round_robin;
    test_fixed_prio;
    test_latency3;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
